// File: rtl/fetch_if.sv
// Fetch front-end signal bundle: instruction-cache lookup, redirect input and the
// valid/ready instruction stream towards decode.
interface fetch_if;
  logic [31:0] icache_addr;
  logic [31:0] icache_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_done;

  modport master (
    output icache_addr,
    input  icache_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetch_done
  );

  modport slave (
    input  icache_addr,
    output icache_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetch_done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, combinational icache lookup and an in-order
// {pc, instr} queue presented to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] END_ADDR = 32'd2208
) (
  input logic   clk,
  input logic   reset,
  fetch_if.master bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] pc_mem_d    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] instr_mem_d [DEPTH];

  logic below_end;
  logic pop;
  logic push;

  assign below_end = (pc_q < END_ADDR);

  // Outputs depend only on registered state.
  assign bus.icache_addr = pc_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_pc      = pc_mem_q[head_q];
  assign bus.out_instr   = instr_mem_q[head_q];
  assign bus.fetch_done  = !below_end && (count_q == '0);

  assign pop = bus.out_valid & bus.out_ready;

  always_comb begin
    push        = 1'b0;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (bus.redirect_valid) begin
      // Flush drops any pop in flight; storage contents are left untouched.
      pc_d    = bus.redirect_pc & ~32'h3;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      push = below_end && ((count_q < cnt_t'(DEPTH)) || pop);
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      if (push) begin
        pc_mem_d[tail_q]    = pc_q;
        instr_mem_d[tail_q] = bus.icache_instr;
        tail_d              = tail_q + ptr_t'(1);
        pc_d                = pc_q + 32'd4;
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end
endmodule
